// File: rtl/mem_xfer_pkg.sv
// -----------------------------------------------------------------------------
// mem_xfer_pkg
// Shared constants and helpers for the cache-line <-> word-memory transfer
// block (mem_line_master / mem_word_seq).
//   - default geometry: 28-bit word address, 32-bit words, 4 words per line
//   - transfer FSM state encodings
//   - line pack/unpack helpers for the default geometry
// Ports: none (package).
// -----------------------------------------------------------------------------
package mem_xfer_pkg;

    localparam int DEF_ADDR_W      = 28;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WORDS       = 4;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int DEF_OFF_W       = $clog2(DEF_WORDS);
    localparam int DEF_LINE_W      = DEF_ADDR_W - DEF_OFF_W;
    localparam int DEF_LINE_BITS   = DEF_DATA_W * DEF_WORDS;

    // Transfer FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Word 0 lands in the least significant bits of the line.
    function automatic logic [DEF_LINE_BITS-1:0] pack_line(
        input logic [DEF_DATA_W-1:0] w3,
        input logic [DEF_DATA_W-1:0] w2,
        input logic [DEF_DATA_W-1:0] w1,
        input logic [DEF_DATA_W-1:0] w0
    );
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [DEF_DATA_W-1:0] line_word(
        input logic [DEF_LINE_BITS-1:0] line,
        input int                       idx
    );
        return line[idx*DEF_DATA_W +: DEF_DATA_W];
    endfunction

endpackage

// File: rtl/mem_word_seq.sv
// -----------------------------------------------------------------------------
// mem_word_seq
// Word-slot sequencer for one line transfer phase. Steps word_idx through
// 0..WORDS-1 while advance_i is high and wraps to 0 after the last word, so
// back-to-back phases (writeback then refill) each start at word 0.
// With MEM_WAIT_EN defined every word slot lasts 1+WAIT_CYCLES cycles;
// otherwise every slot is a single cycle and no wait counter exists.
// Ports:
//   clk, rst       clock, async active-low reset
//   start_i        clear counters (new request accepted)
//   advance_i      a transfer phase is running
//   word_idx_o     current word within the line
//   slot_last_o    current cycle is the final cycle of the word slot
//   phase_done_o   final cycle of the final word of the phase
// -----------------------------------------------------------------------------
module mem_word_seq #(
    parameter int WORDS = 4
`ifdef MEM_WAIT_EN
    , parameter int WAIT_CYCLES = 1
`endif
    , localparam int OFF_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             advance_i,
    output logic [OFF_W-1:0] word_idx_o,
    output logic             slot_last_o,
    output logic             phase_done_o
);

    logic [OFF_W-1:0] idx_q, idx_d;
    logic             slot_last;

`ifdef MEM_WAIT_EN
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [WAIT_W-1:0] wait_q, wait_d;

    assign slot_last = (wait_q == WAIT_W'(WAIT_CYCLES));

    always_comb begin
        wait_d = wait_q;
        if (start_i || !advance_i || slot_last) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign slot_last = 1'b1;
`endif

    // WORDS is a power of two, so the increment wraps to 0 after the last word.
    always_comb begin
        idx_d = idx_q;
        if (start_i || !advance_i) begin
            idx_d = '0;
        end else if (slot_last) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign word_idx_o   = idx_q;
    assign slot_last_o  = slot_last;
    assign phase_done_o = advance_i && slot_last && (idx_q == OFF_W'(WORDS - 1));

endmodule

// File: rtl/mem_line_master.sv
// -----------------------------------------------------------------------------
// mem_line_master
// Cache-side initiator for a word-wide memory bank. Turns one line request into
// single-word accesses: victim writeback, line refill, or writeback then refill.
// Memory read data is combinational for the presented mem_addr.
// Optional build macro: MEM_WAIT_EN (stretch every word slot by WAIT_CYCLES).
// Ports:
//   clk, rst                         clock, async active-low reset
//   req_valid/req_ready              line request handshake (ready == idle)
//   req_wb, req_fill                 operations requested
//   req_wb_addr, req_fill_addr       victim / refill line addresses
//   req_wb_line                      victim data, word i at [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_ready, rsp_line    completion handshake and refilled line
//   mem_addr, mem_write_en,
//   mem_wdata, mem_rdata             memory bank interface
// -----------------------------------------------------------------------------
module mem_line_master
    import mem_xfer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WORDS       = DEF_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    localparam int OFF_W      = $clog2(WORDS),
    localparam int LINE_W     = ADDR_W - OFF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wb,
    input  logic                    req_fill,
    input  logic [LINE_W-1:0]       req_wb_addr,
    input  logic [LINE_W-1:0]       req_fill_addr,
    input  logic [DATA_W*WORDS-1:0] req_wb_line,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W*WORDS-1:0] rsp_line,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_write_en,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    // state   | meaning
    // IDLE    | waiting for a line request, req_ready high
    // WB      | writing the captured victim line, one word per slot
    // FILL    | reading the refill line into rsp_line, one word per slot
    // RESP    | rsp_valid held until the cache takes it

    logic [1:0]              state_q, state_d;
    logic [LINE_W-1:0]       wb_addr_q, fill_addr_q;
    logic [DATA_W*WORDS-1:0] wb_line_q, rsp_line_q;
    logic                    fill_q;

    logic                    accept;
    logic                    in_xfer;
    logic [OFF_W-1:0]        word_idx;
    logic                    slot_last;
    logic                    phase_done;

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign in_xfer = (state_q == ST_WB) || (state_q == ST_FILL);

`ifndef MEM_WAIT_EN
    // Slot stretching is compiled out; the parameter is kept for a uniform interface.
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    mem_word_seq #(
        .WORDS       (WORDS)
`ifdef MEM_WAIT_EN
        , .WAIT_CYCLES (WAIT_CYCLES)
`endif
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .start_i      (accept),
        .advance_i    (in_xfer),
        .word_idx_o   (word_idx),
        .slot_last_o  (slot_last),
        .phase_done_o (phase_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)     state_d = req_wb ? ST_WB : (req_fill ? ST_FILL : ST_RESP);
            ST_WB:   if (phase_done) state_d = fill_q ? ST_FILL : ST_RESP;
            ST_FILL: if (phase_done) state_d = ST_RESP;
            ST_RESP: if (rsp_ready)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wb_addr_q   <= '0;
            fill_addr_q <= '0;
            wb_line_q   <= '0;
            fill_q      <= 1'b0;
            rsp_line_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wb_addr_q   <= req_wb_addr;
                fill_addr_q <= req_fill_addr;
                wb_line_q   <= req_wb_line;
                fill_q      <= req_fill;
            end
            // Read data is combinational, so it is captured at the edge closing the slot.
            if ((state_q == ST_FILL) && slot_last) begin
                rsp_line_q[32'(word_idx)*DATA_W +: DATA_W] <= mem_rdata;
            end
        end
    end

    // Address and data are held for the whole slot; the strobe fires only in its last cycle.
    always_comb begin
        mem_addr     = '0;
        mem_write_en = 1'b0;
        mem_wdata    = '0;
        if (state_q == ST_WB) begin
            mem_addr     = {wb_addr_q, word_idx};
            mem_write_en = slot_last;
            mem_wdata    = wb_line_q[32'(word_idx)*DATA_W +: DATA_W];
        end else if (state_q == ST_FILL) begin
            mem_addr     = {fill_addr_q, word_idx};
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_line  = rsp_line_q;

endmodule

// File: tb/tb_mem_line_master.sv
// -----------------------------------------------------------------------------
// tb_mem_line_master
// Directed bench for mem_line_master with a 256-word combinational bank model.
// Build with MEM_WAIT_EN to exercise the stretched word slots (WAIT_CYCLES=2).
// -----------------------------------------------------------------------------
module tb_mem_line_master;
    import mem_xfer_pkg::*;

`ifdef MEM_WAIT_EN
    localparam int SLOT = 3;
`else
    localparam int SLOT = 1;
`endif
    localparam int WORDS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_wb, req_fill;
    logic [25:0]  req_wb_addr, req_fill_addr;
    logic [127:0] req_wb_line;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_line;
    logic [27:0]  mem_addr;
    logic         mem_write_en;
    logic [31:0]  mem_wdata, mem_rdata;

    logic [31:0]  bank [256];
    logic         preload;

    logic [27:0]  log_addr [64];
    logic         log_we   [64];
    logic [31:0]  log_wd   [64];

    int asserts = 0;
    int fails   = 0;
    int lat;

    always #5 clk = ~clk;

    mem_line_master #(.WAIT_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wb        (req_wb),
        .req_fill      (req_fill),
        .req_wb_addr   (req_wb_addr),
        .req_fill_addr (req_fill_addr),
        .req_wb_line   (req_wb_line),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_line      (rsp_line),
        .mem_addr      (mem_addr),
        .mem_write_en  (mem_write_en),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    assign mem_rdata = bank[mem_addr[7:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) bank[i] <= 32'h0;
            bank[0] <= 32'h50;
            bank[1] <= 32'h60;
            bank[2] <= 32'h70;
            bank[3] <= 32'h80;
        end else if (mem_write_en) begin
            bank[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, then log the memory interface every cycle until rsp_valid.
    task automatic start_op(input logic w, input logic f, input logic [25:0] wa,
                            input logic [25:0] fa, input logic [127:0] line, output int n);
        int guard;
        req_wb = w; req_fill = f; req_wb_addr = wa; req_fill_addr = fa;
        req_wb_line = line; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin step(); guard++; end
        step();
        req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
        n = 0;
        while (!rsp_valid && n < 64) begin
            log_addr[n] = mem_addr; log_we[n] = mem_write_en; log_wd[n] = mem_wdata;
            step();
            n++;
        end
    endtask

    task automatic finish_op();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic check_phase(input string tag, input logic wb, input logic [27:0] base,
                               input int k0, input logic [127:0] line);
        for (int k = 0; k < WORDS*SLOT; k++) begin
            int idx;
            idx = k / SLOT;
            chk($sformatf("%s_addr%0d", tag, k), 128'(log_addr[k0+k]), 128'(base + 28'(idx)));
            chk($sformatf("%s_we%0d", tag, k), 128'(log_we[k0+k]),
                128'(wb && ((k % SLOT) == SLOT - 1)));
            chk($sformatf("%s_wd%0d", tag, k), 128'(log_wd[k0+k]),
                wb ? 128'(line_word(line, idx)) : 128'h0);
        end
    endtask

    initial begin
        logic [127:0] ln_a, ln_b, ln_c, ln_d, ln_e, ln_fill0;
        ln_fill0 = pack_line(32'h80, 32'h70, 32'h60, 32'h50);
        ln_a     = pack_line(32'hD, 32'hC, 32'hB, 32'hA);
        ln_b     = pack_line(32'h4, 32'h3, 32'h2, 32'h1);
        ln_c     = pack_line(32'h44, 32'h33, 32'h22, 32'h11);
        ln_d     = pack_line(32'hEE, 32'hEE, 32'hEE, 32'hEE);
        ln_e     = pack_line(32'h99, 32'h98, 32'h97, 32'h96);

        rst = 1'b0; preload = 1'b1;
        req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
        req_wb_addr = '0; req_fill_addr = '0; req_wb_line = '0; rsp_ready = 1'b0;
        step(); step();
        preload = 1'b0;
        chk("rst_req_ready", 128'(req_ready), 128'h1);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("rst_rsp_line", rsp_line, 128'h0);
        chk("rst_mem_addr", 128'(mem_addr), 128'h0);
        chk("rst_mem_we", 128'(mem_write_en), 128'h0);
        chk("rst_mem_wdata", 128'(mem_wdata), 128'h0);
        rst = 1'b1;
        step();

        // fill line 0
        start_op(1'b0, 1'b1, 26'd0, 26'd0, 128'h0, lat);
        chk("t1_latency", 128'(lat), 128'(WORDS*SLOT));
        check_phase("t1_fill", 1'b0, 28'd0, 0, 128'h0);
        chk("t1_rsp_line", rsp_line, ln_fill0);
        finish_op();
        chk("t1_rsp_dropped", 128'(rsp_valid), 128'h0);

        // writeback line 2
        start_op(1'b1, 1'b0, 26'd2, 26'd0, ln_a, lat);
        chk("t2_latency", 128'(lat), 128'(WORDS*SLOT));
        check_phase("t2_wb", 1'b1, 28'd8, 0, ln_a);
        finish_op();
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_bank%0d", 8 + i), 128'(bank[8+i]), 128'(32'hA + 32'(i)));

        // writeback then refill of the same line
        start_op(1'b1, 1'b1, 26'd1, 26'd1, ln_b, lat);
        chk("t3_latency", 128'(lat), 128'(2*WORDS*SLOT));
        check_phase("t3_wb", 1'b1, 28'd4, 0, ln_b);
        check_phase("t3_fill", 1'b0, 28'd4, WORDS*SLOT, 128'h0);
        chk("t3_rsp_line", rsp_line, ln_b);
        finish_op();

        // neither operation: immediate response, rsp_line keeps last refill
        start_op(1'b0, 1'b0, 26'd5, 26'd6, ln_d, lat);
        chk("none_latency", 128'(lat), 128'h0);
        chk("none_rsp_line", rsp_line, ln_b);
        finish_op();

        // all-ones line address stays inside its line
        start_op(1'b1, 1'b0, 26'h3FFFFFF, 26'd0, ln_c, lat);
        check_phase("top_wb", 1'b1, 28'hFFFFFFC, 0, ln_c);
        finish_op();
        start_op(1'b0, 1'b1, 26'd0, 26'h3FFFFFF, 128'h0, lat);
        check_phase("top_fill", 1'b0, 28'hFFFFFFC, 0, 128'h0);
        chk("top_rsp_line", rsp_line, ln_c);
        chk("top_no_wrap", 128'(bank[0]), 128'h50);
        finish_op();

        // response back-pressure with a competing request
        start_op(1'b0, 1'b1, 26'd0, 26'd0, 128'h0, lat);
        req_wb = 1'b1; req_wb_addr = 26'd3; req_wb_line = ln_d; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4_rsp_valid%0d", c), 128'(rsp_valid), 128'h1);
            chk($sformatf("t4_rsp_line%0d", c), rsp_line, ln_fill0);
            chk($sformatf("t4_req_ready%0d", c), 128'(req_ready), 128'h0);
            chk($sformatf("t4_we%0d", c), 128'(mem_write_en), 128'h0);
            step();
        end
        req_valid = 1'b0; req_wb = 1'b0;
        finish_op();
        chk("t4_rsp_dropped", 128'(rsp_valid), 128'h0);
        chk("t4_idle", 128'(req_ready), 128'h1);
        step(); step();
        chk("t4_ignored_bank12", 128'(bank[12]), 128'h0);

        // reset during writeback word 2
        start_op_partial: begin
            req_wb = 1'b1; req_wb_addr = 26'd3; req_wb_line = ln_e; req_valid = 1'b1;
            step();
            req_valid = 1'b0; req_wb = 1'b0;
            for (int c = 0; c < 2*SLOT; c++) step();
            chk("t5_word2_addr", 128'(mem_addr), 128'd14);
            rst = 1'b0;
            #1;
            chk("t5_we_cut", 128'(mem_write_en), 128'h0);
            chk("t5_addr_cut", 128'(mem_addr), 128'h0);
            step(); step();
            rst = 1'b1;
            step();
            chk("t5_req_ready", 128'(req_ready), 128'h1);
            chk("t5_rsp_valid", 128'(rsp_valid), 128'h0);
            chk("t5_rsp_line", rsp_line, 128'h0);
            chk("t5_bank12", 128'(bank[12]), 128'h96);
            chk("t5_bank13", 128'(bank[13]), 128'h97);
            chk("t5_bank14", 128'(bank[14]), 128'h0);
            chk("t5_bank15", 128'(bank[15]), 128'h0);
        end

        // normal operation resumes after the abort
        start_op(1'b0, 1'b1, 26'd0, 26'd0, 128'h0, lat);
        chk("post_latency", 128'(lat), 128'(WORDS*SLOT));
        chk("post_rsp_line", rsp_line, ln_fill0);
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
